// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared widths, reset PC, NOP encoding and the buffered fetch entry.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sync_fifo
// Brief    : Parameterised synchronous FIFO with clear and occupancy count;
//            push and pop in the same cycle are accepted even when full.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = pop && (r_count != '0);
    // A simultaneous pop frees the slot, so a push at full is still taken.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buffer
// Brief    : Fetch front-end: sequential PC generation, pipelined memory
//            requests, response FIFO and redirect flush. Optional feature
//            macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-target flag).
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            fetch_misalign,
`endif
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pcplus4
);

    localparam int FCW = $clog2(DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [TCW-1:0]  r_drop_cnt;
    logic [FCW-1:0]  w_fifo_count;
    logic [TCW-1:0]  w_tag_count;
    logic [XLEN-1:0] w_tag_pc;
    fetch_entry_t    w_head;
    fetch_entry_t    w_rsp_entry;
    logic [31:0]     w_occupancy;
    logic            w_fetch_block;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_deq;
    logic            w_nonempty;

    // Stale in-flight words still count as outstanding but will never land.
    assign w_occupancy = 32'(w_fifo_count) + 32'(w_tag_count) - 32'(r_drop_cnt);

    assign mem_req_valid = !rst && !redirect_valid && !w_fetch_block
                         && (32'(w_tag_count) < 32'(MAX_OUTSTANDING))
                         && (w_occupancy < 32'(DEPTH));
    assign mem_req_addr  = r_fetch_pc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    assign w_rsp_keep  = mem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_rsp_entry = fetch_entry_t'{pc: w_tag_pc, inst: mem_rsp_data};

    assign w_nonempty = (w_fifo_count != '0);
    assign inst_valid = w_nonempty && !redirect_valid;
    assign w_deq      = inst_valid && inst_ready;

    assign inst_data    = w_nonempty ? w_head.inst       : '0;
    assign inst_pc      = w_nonempty ? w_head.pc         : '0;
    assign inst_pcplus4 = w_nonempty ? pc_plus4(w_head.pc) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fetch_pc <= RESET_PC;
        else if (redirect_valid)
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (w_req_fire)
            r_fetch_pc <= pc_plus4(r_fetch_pc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (redirect_valid)
            r_drop_cnt <= w_tag_count - TCW'(mem_rsp_valid);
        else if (mem_rsp_valid && (r_drop_cnt != '0))
            r_drop_cnt <= r_drop_cnt - TCW'(1);
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            r_misalign <= 1'b1;
    end

    assign fetch_misalign = r_misalign;
    assign w_fetch_block  = r_misalign;
`else
    logic [1:0] w_unused_pc_lo;

    assign w_unused_pc_lo = redirect_pc[1:0];
    assign w_fetch_block  = 1'b0;
`endif

    // Tag queue is never flushed: dropped responses must still retire their tag.
    fetch_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (w_req_fire),
        .push_data (r_fetch_pc),
        .pop       (mem_rsp_valid),
        .pop_data  (w_tag_pc),
        .count     (w_tag_count)
    );

    fetch_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_valid),
        .push      (w_rsp_keep),
        .push_data (w_rsp_entry),
        .pop       (w_deq),
        .pop_data  (w_head),
        .count     (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_buffer
// Brief    : Directed vector table plus randomized traffic against a
//            queue-based fetch/memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [31:0] TBL_RPC = 32'h0000_0100;
`else
    localparam logic [31:0] TBL_RPC = 32'h0000_0103;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pcplus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    inst_fetch_buffer #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pcplus4   (inst_pcplus4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Reference model: memory requests in flight (with stale marks) and
    // PCs of words sitting in the buffer, oldest first.
    typedef struct {
        logic [31:0] pc;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] bq[$];
    logic [31:0] m_fetch;
    bit          m_mis;
    int          cyc;

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        #1;
        chk("rst_req_valid",  32'(mem_req_valid), 32'd0);
        chk("rst_req_addr",   mem_req_addr, RPC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data",  inst_data, 32'd0);
        chk("rst_inst_pc",    inst_pc, 32'd0);
        chk("rst_pcplus4",    inst_pcplus4, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misalign",   32'(fetch_misalign), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); bq.delete();
        m_fetch = RPC; m_mis = 1'b0; cyc = 0;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                        input bit mrdy, input int lat);
        bit          rv, e_rv, e_iv;
        int          live;
        logic [31:0] e_pc;
        mreq_t       e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        mem_req_ready  = mrdy;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        mem_rsp_valid = rv;
        mem_rsp_data  = rv ? memword(mq[0].pc) : $urandom;
        @(negedge clk);
        live = 0;
        for (int i = 0; i < mq.size(); i++) if (!mq[i].stale) live++;
        e_rv = !redir && !m_mis && (mq.size() < MAXO) && ((bq.size() + live) < DEPTH);
        e_iv = (bq.size() > 0) && !redir;
        e_pc = (bq.size() > 0) ? bq[0] : 32'd0;
        chk("req_valid",  32'(mem_req_valid), 32'(e_rv));
        chk("req_addr",   mem_req_addr, m_fetch);
        chk("inst_valid", 32'(inst_valid), 32'(e_iv));
        chk("inst_pc",    inst_pc, e_pc);
        chk("inst_data",  inst_data, (bq.size() > 0) ? memword(e_pc) : 32'd0);
        chk("pcplus4",    inst_pcplus4, (bq.size() > 0) ? e_pc + 32'd4 : 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign",   32'(fetch_misalign), 32'(m_mis));
`endif
        if (e_iv && rdy) void'(bq.pop_front());
        if (rv) begin
            e = mq.pop_front();
            if (!e.stale && !redir) bq.push_back(e.pc);
        end
        if (e_rv && mrdy) begin
            mq.push_back('{pc: m_fetch, due: cyc + lat, stale: 1'b0});
            m_fetch = m_fetch + 32'd4;
        end
        if (redir) begin
            bq.delete();
            for (int i = 0; i < mq.size(); i++) mq[i].stale = 1'b1;
            m_fetch = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
`endif
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int p_rdy, input int p_mrdy, input int p_redir,
                       input int lat_lo, input int lat_hi);
        for (int k = 0; k < n; k++) begin
            bit          redir;
            logic [31:0] t;
            redir = ($urandom_range(0, 99) < p_redir);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + ($urandom & 32'hF))
                                            : ($urandom & 32'h0000_0FFF);
`ifdef FETCH_MISALIGN_CHECK_EN
            t[1:0] = 2'b00;
`endif
            step(redir, t, ($urandom_range(0, 99) < p_rdy), ($urandom_range(0, 99) < p_mrdy),
                 int'($urandom_range(lat_lo, lat_hi)));
        end
    endtask

    typedef struct {
        bit          redir;
        logic [31:0] rpc;
        bit          rdy;
        bit          mrdy;
        bit          rspv;
        logic [31:0] rsp_pc;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        bit          e_head;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // redir rpc rdy mrdy rspv rsp_pc | req_valid addr inst_valid head inst_pc
        tbl[0] = '{0, 0,       1, 1, 0, 0,       1, 32'h000, 0, 0, 32'h000};
        tbl[1] = '{0, 0,       1, 1, 1, 32'h000, 1, 32'h004, 0, 0, 32'h000};
        tbl[2] = '{0, 0,       1, 1, 1, 32'h004, 1, 32'h008, 1, 1, 32'h000};
        tbl[3] = '{0, 0,       0, 1, 0, 0,       1, 32'h00C, 1, 1, 32'h004};
        tbl[4] = '{1, TBL_RPC, 1, 1, 1, 32'h008, 0, 32'h010, 0, 1, 32'h004};
        tbl[5] = '{0, 0,       1, 0, 1, 32'h00C, 1, 32'h100, 0, 0, 32'h000};
        tbl[6] = '{0, 0,       1, 1, 0, 0,       1, 32'h100, 0, 0, 32'h000};
        tbl[7] = '{0, 0,       1, 0, 1, 32'h100, 1, 32'h104, 0, 0, 32'h000};
        tbl[8] = '{0, 0,       1, 0, 0, 0,       1, 32'h104, 1, 1, 32'h100};
        tbl[9] = '{0, 0,       1, 0, 0, 0,       1, 32'h104, 0, 0, 32'h000};

        do_reset();

        for (int r = 0; r < 10; r++) begin
            redirect_valid = tbl[r].redir;
            redirect_pc    = tbl[r].rpc;
            inst_ready     = tbl[r].rdy;
            mem_req_ready  = tbl[r].mrdy;
            mem_rsp_valid  = tbl[r].rspv;
            mem_rsp_data   = memword(tbl[r].rsp_pc);
            @(negedge clk);
            chk($sformatf("tbl%0d_req_valid", r),  32'(mem_req_valid), 32'(tbl[r].e_rv));
            chk($sformatf("tbl%0d_req_addr", r),   mem_req_addr, tbl[r].e_addr);
            chk($sformatf("tbl%0d_inst_valid", r), 32'(inst_valid), 32'(tbl[r].e_iv));
            chk($sformatf("tbl%0d_inst_pc", r),    inst_pc, tbl[r].e_pc);
            chk($sformatf("tbl%0d_inst_data", r),  inst_data,
                tbl[r].e_head ? memword(tbl[r].e_pc) : 32'd0);
            chk($sformatf("tbl%0d_pcplus4", r),    inst_pcplus4,
                tbl[r].e_head ? tbl[r].e_pc + 32'd4 : 32'd0);
            @(posedge clk);
            #1;
        end

        do_reset();
        run(40, 100, 100, 0, 1, 1);        // zero-wait streaming
        run(10, 0, 100, 0, 1, 1);          // decode stalled: buffer saturates
        run(20, 100, 100, 0, 1, 1);
        run(60, 100, 50, 0, 3, 3);         // latency 3, toggling ready
        run(600, 70, 70, 5, 1, 4);         // mixed traffic with redirects
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
        run(20, 100, 100, 0, 1, 2);        // PC wrap through zero
        run(7, 80, 80, 0, 1, 3);
        do_reset();                        // reset mid-stream
        run(150, 80, 80, 5, 1, 3);
`ifdef FETCH_MISALIGN_CHECK_EN
        step(1'b1, 32'h0000_0102, 1'b1, 1'b1, 1);
        run(15, 100, 100, 0, 1, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
Fetch front-end directly upstream of the pipelined RISC-V core's decode stage.
- Generates sequential PCs and issues pipelined requests to a variable-latency instruction memory (valid/ready request channel, in-order response channel).
- Buffers returned words with their PC in a small FIFO.
- Presents {inst, pc, pc+4} to decode with a valid/ready handshake.
- Execute-stage redirects (branch/jal/jalr taken) flush the buffer and discard stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
MAX_OUTSTANDING, 2, max requests in flight to memory (1..DEPTH)
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
redirect_valid  in  1  execute-stage redirect (PCSrcE != sequential)
redirect_pc  in  32  redirect target
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  byte address of fetch
mem_rsp_valid  in  1  response word valid (in request order, always accepted)
mem_rsp_data  in  32  instruction word
inst_valid  out  1  buffered instruction available to decode
inst_ready  in  1  decode accepts (low = StallD)
inst_data  out  32  instruction
inst_pc  out  32  PC of instruction
inst_pcplus4  out  32  inst_pc + 4, modulo 2^32

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs: mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, inst_pcplus4=0, mem_req_addr=RESET_PC.
- Request issue:
  - mem_req_valid=1 iff !redirect_valid && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding−drop_cnt)<DEPTH.
  - Buffer can therefore never overflow; responses are never back-pressured.
  - mem_req_addr=fetch_pc. On req fire, fetch_pc+=4 (wraps 32'hFFFF_FFFC→0).
  - Each pending request's PC is pushed into an internal tag queue (depth MAX_OUTSTANDING).
- Response:
  - If drop_cnt>0: discard word, drop_cnt−=1, pop tag.
  - Else: push {tag_pc, mem_rsp_data} into FIFO, pop tag.
  - outstanding_next = outstanding + req_fire − rsp_fire.
- Output:
  - inst_valid = FIFO non-empty && !redirect_valid; inst_* driven from FIFO head (zeros when empty).
  - Dequeue on inst_valid && inst_ready.
  - Push and pop in the same cycle are legal, including at full.
  - Latency: empty buffer, zero-wait memory → instruction valid the cycle after response arrives (response registered into FIFO).
- Redirect (single-cycle pulse, highest priority):
  - FIFO cleared.
  - fetch_pc<=redirect_pc.
  - No request and no dequeue that cycle.
  - drop_cnt <= outstanding − rsp_fire (any response that same cycle is also discarded).
  - Next cycle requests start at redirect_pc.
- Back-to-back redirects: each restarts; drop_cnt recomputed from the current outstanding count.
- redirect_pc[1:0] is ignored by fetch (aligned to {redirect_pc[31:2],2'b00}).
- Reset mid-stream: all state cleared. Memory responses to pre-reset requests are the memory's responsibility (memory is reset by the same rst).

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: extra output fetch_misalign (1 bit, reset 0).
  - Set sticky when redirect_valid && redirect_pc[1:0]!=0.
  - While set, mem_req_valid forced 0; buffered instructions still drain.
  - Cleared only by rst.
- Undefined: no port; low bits are silently masked.

Decomposition:
- Package fetch_pkg:
  - XLEN=32, DEFAULT_RESET_PC, NOP encoding 32'h0000_0013.
  - Typedef fetch_entry_t {pc[31:0], inst[31:0]}.
- One sub-module: fetch_sync_fifo, a parameterised synchronous FIFO with async active-high reset and count output.
  - Instanced twice: DEPTH-entry instruction buffer, MAX_OUTSTANDING-entry tag queue.

Test Plan:
- Zero-wait memory, inst_ready=1, RESET_PC=0 → requests 0,4,8,…; first inst_valid two cycles after reset release with inst_pc=0, inst_pcplus4=4; one instruction per cycle thereafter.
- inst_ready=0 for 10 cycles → fifo_count saturates at 4, mem_req_valid=0, no lost or duplicated PCs after release (sequence 0,4,8,12,16 intact).
- Memory latency 3, mem_req_ready toggling → never more than 2 outstanding; output PCs strictly +4 in order.
- Two requests in flight (PCs 8, 12), redirect to 32'h100 → both responses dropped; next inst_pc=32'h100, then 32'h104.
- Redirect in same cycle as response and inst_ready=1 → no dequeue, response discarded, inst_valid=0 that cycle; stream resumes at target.
- With FETCH_MISALIGN_CHECK_EN: redirect_pc=32'h102 → fetch_misalign=1 next cycle, mem_req_valid stays 0 until rst.
